// File: rtl/alu_mem_pkg.sv
// alu_mem_pkg: shared op encodings, FSM states and memory word width
package alu_mem_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    // stored word is {c, y}: one flag bit above the 2W-bit result
    function automatic int mem_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: W-cycle restoring divider, one quotient bit per cycle
module alu_div_iter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  div_q, div_d;
    logic [W:0]    trial, diff;
    logic          ge, last;

    // shift the next dividend bit into the remainder and subtract when it fits
    always_comb begin
        trial  = {rem_q, quot_q[W-1]};
        diff   = trial - {1'b0, div_q};
        ge     = trial >= {1'b0, div_q};
        last   = busy_q && cnt_q == CW'(W - 1);
        busy_d = start ? 1'b1 : last ? 1'b0 : busy_q;
        cnt_d  = start ? '0 : (busy_q && !last) ? cnt_q + CW'(1) : cnt_q;
        quot_d = start ? a : busy_q ? {quot_q[W-2:0], ge} : quot_q;
        rem_d  = start ? '0 : busy_q ? (ge ? diff[W-1:0] : trial[W-1:0]) : rem_q;
        div_d  = start ? b : div_q;
        busy   = busy_q;
        done   = last;
        quot   = quot_q;
        rem    = rem_q;
    end

    // divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
        end
    end

endmodule

// File: rtl/alu_mem_seq.sv
// alu_mem_seq: handshaked add/sub/mul/div unit with a result memory
module alu_mem_seq
    import alu_mem_pkg::*;
#(
    parameter  int W     = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     op,
    input  logic [AW-1:0]  addr,
    input  logic           we,
    output logic           out_valid,
    output logic [2*W-1:0] y,
    output logic           c,
    input  logic [AW-1:0]  rd_addr,
    output logic [2*W:0]   rd_data
);

    localparam int MW = mem_w(W);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [2*W-1:0]  y_q, y_d, res_y, ea, eb;
    logic            c_q, c_d, res_c;
    logic [MW-1:0]   rd_data_q, rd_data_d;
    logic [MW-1:0]   mem_q [DEPTH];
    logic [MW-1:0]   mem_d [DEPTH];
    logic            accept, fire, div_start, div_busy, div_done;
    logic [W-1:0]    quot, rem;

    alu_div_iter #(.W(W)) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .a     (a),
        .b     (b),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (quot),
        .rem   (rem)
    );

    // handshake, state sequencing and operand capture on accept
    always_comb begin
        in_ready  = state_q == IDLE && !rst;
        accept    = in_valid && in_ready;
        div_start = accept && op == OP_DIV && b != '0;
        fire      = state_q == DONE && !rst;
        state_d   = state_q == IDLE ? (accept ? (div_start ? DIV : DONE) : IDLE)
                  : state_q == DIV  ? ((div_done || !div_busy) ? DONE : DIV)
                  : IDLE;
        a_d       = accept ? a : a_q;
        b_d       = accept ? b : b_q;
        op_d      = accept ? op : op_q;
        addr_d    = accept ? addr : addr_q;
        we_d      = accept ? we : we_q;
    end

    // result from latched operands; shown in DONE and held afterwards
    always_comb begin
        ea        = {{W{1'b0}}, a_q};
        eb        = {{W{1'b0}}, b_q};
        res_y     = op_q == OP_ADD ? ea + eb
                  : op_q == OP_SUB ? ea - eb
                  : op_q == OP_MUL ? ea * eb
                  : b_q == '0 ? '0 : {rem, quot};
        res_c     = op_q == OP_ADD ? res_y[W]
                  : op_q == OP_SUB ? a_q < b_q
                  : op_q == OP_DIV && b_q == '0;
        y_d       = fire ? res_y : y_q;
        c_d       = fire ? res_c : c_q;
        y         = y_d;
        c         = c_d;
        out_valid = fire;
        rd_data_d = mem_q[rd_addr];
        rd_data   = rd_data_q;
        for (int i = 0; i < DEPTH; i++)
            mem_d[i] = (fire && we_q && addr_q == AW'(i)) ? {res_c, res_y} : mem_q[i];
    end

    // state, result and memory registers; reset clears the whole array
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            y_q       <= '0;
            c_q       <= 1'b0;
            rd_data_q <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            y_q       <= y_d;
            c_q       <= c_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

endmodule
